// File: rtl/psa_seq_ctrl_if.sv
// psa_seq_ctrl_if: operand/result handshake bundle between the issue logic, the packed-add sequencer and writeback
interface psa_seq_ctrl_if #(parameter int LANE_W = 4, parameter int LANES = 4);
    localparam int DW = LANE_W * LANES;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    a;
    logic [DW-1:0]    b;
    logic             sat;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    sum;
    logic [LANES-1:0] lane_ovfl;
    logic             error;
    logic             busy;
    modport master (
        output in_valid, a, b, sat, abort, out_ready,
        input  in_ready, out_valid, sum, lane_ovfl, error, busy
    );
    modport slave (
        input  in_valid, a, b, sat, abort, out_ready,
        output in_ready, out_valid, sum, lane_ovfl, error, busy
    );
endinterface

// File: rtl/psa_seq_ctrl.sv
// psa_seq_ctrl: packed 4x4-bit add sequencer; one shared lane adder walks lanes 0..LANES-1, one per cycle
module psa_seq_ctrl #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input logic           clk,
    input logic           rst_n,
    psa_seq_ctrl_if.slave bus
);
    localparam int DW = LANE_W * LANES;
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int M  = LANE_W - 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [DW-1:0]    a_q, b_q, sum_q;
    logic [LANES-1:0] ovfl_q;
    logic [IW-1:0]    idx_q;
    logic             sat_q, in_ready_q, out_valid_q, busy_q;
    logic [LANE_W-1:0] a_l, b_l, s_l, lane_d;
    logic              ovf_d;
    assign a_l = a_q[idx_q*LANE_W +: LANE_W];
    assign b_l = b_q[idx_q*LANE_W +: LANE_W];
    assign s_l = a_l + b_l;
    assign ovf_d = (a_l[M] == b_l[M]) && (s_l[M] != a_l[M]);
    // Saturate toward the sign of the operands: max positive or min negative
    assign lane_d = (ovf_d && sat_q) ? (a_l[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}}) : s_l;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sat_q       <= 1'b0;
            sum_q       <= '0;
            ovfl_q      <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (bus.abort) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            ovfl_q      <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    state_q    <= RUN;
                    a_q        <= bus.a;
                    b_q        <= bus.b;
                    sat_q      <= bus.sat;
                    sum_q      <= '0;
                    ovfl_q     <= '0;
                    idx_q      <= '0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                RUN: begin
                    sum_q[idx_q*LANE_W +: LANE_W] <= lane_d;
                    ovfl_q[idx_q]                 <= ovf_d;
                    idx_q                         <= idx_q + IW'(1);
                    if (idx_q == IW'(LANES - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.lane_ovfl = ovfl_q;
    assign bus.error     = |ovfl_q;
endmodule

// File: tb/tb_psa_seq_ctrl.sv
// tb_psa_seq_ctrl: directed and random packed-add operations checked against a signed-arithmetic lane model
module tb_psa_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int failures = 0;
    psa_seq_ctrl_if bus ();
    psa_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask
    // Returns {lane_ovfl, sum}: each lane is a signed add, overflow when outside [-8,7]
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [15:0] r;
        logic [3:0]  o;
        int x, y, t;
        for (int i = 0; i < 4; i++) begin
            x = int'(a[4*i +: 4]);
            y = int'(b[4*i +: 4]);
            if (x > 7) x -= 16;
            if (y > 7) y -= 16;
            t = x + y;
            o[i] = (t > 7) || (t < -8);
            if (o[i] && s) t = (t > 7) ? 7 : -8;
            r[4*i +: 4] = 4'(t);
        end
        return {o, r};
    endfunction
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold);
        logic [19:0] e;
        logic [15:0] held_sum;
        int n;
        e = model(a, b, s);
        @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.sat = s;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.sat = 1'($urandom);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd4);
        chk("sum", 32'(bus.sum), 32'(e[15:0]));
        chk("lane_ovfl", 32'(bus.lane_ovfl), 32'(e[19:16]));
        chk("error", 32'(bus.error), 32'(|e[19:16]));
        held_sum = bus.sum;
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = 1'($urandom);
            bus.a = 16'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_sum", 32'(bus.sum), 32'(held_sum));
            chk("hold_ovfl", 32'(bus.lane_ovfl), 32'(e[19:16]));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("handoff_valid", 32'(bus.out_valid), 32'd0);
        chk("handoff_in_ready", 32'(bus.in_ready), 32'd1);
        chk("handoff_busy", 32'(bus.busy), 32'd0);
        bus.out_ready = 1'b0;
    endtask
    // Starts 0x7777+0x1111 and returns at the negedge inside the second RUN cycle
    task automatic start_and_stall();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 16'h7777;
        bus.b = 16'h1111;
        bus.sat = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask
    task automatic expect_idle_quiet(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_sum"}, 32'(bus.sum), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk({tag, "_no_valid"}, 32'(bus.out_valid), 32'd0);
        end
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sat = 1'b0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        #7 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h1234, 16'h1111, 1'b0, 0);
        do_op(16'h7777, 16'h1111, 1'b0, 0);
        do_op(16'h7777, 16'h1111, 1'b1, 0);
        do_op(16'h88F0, 16'h8F1F, 1'b1, 0);
        do_op(16'h88F0, 16'h8F1F, 1'b0, 3);
        start_and_stall();
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        expect_idle_quiet("abort");
        @(negedge clk);
        bus.abort = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_beats_accept", 32'(bus.busy), 32'd0);
        start_and_stall();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        expect_idle_quiet("rst_mid");
        rst_n = 1'b1;
        do_op(16'h1234, 16'h1111, 1'b0, 0);
        for (int i = 0; i < 20; i++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psa_seq_ctrl.md
Name: psa_seq_ctrl

Overview:
Sequencer for the packed sub-word (4x4-bit) add datapath. It accepts one 16-bit operand pair over a valid/ready handshake and time-multiplexes a single internal LANE_W-bit adder across the LANES nibbles, one lane per cycle. It produces the packed sum, per-lane signed-overflow flags, an aggregate error bit and optional per-lane saturation. It sits between the decode/execute issue logic and the writeback of the packed-add result.

Parameters:
LANE_W, 4, width of one sub-word lane in bits.
LANES, 4, number of lanes; data width DW = LANE_W*LANES = 16.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand pair presented.
in_ready  out  1  block can accept; high only in IDLE.
a  in  DW  operand A, lane i = a[LANE_W*i +: LANE_W].
b  in  DW  operand B, same lane mapping.
sat  in  1  1 = saturate overflowing lanes, 0 = wrap; sampled at accept.
abort  in  1  synchronous flush, highest priority after reset.
out_valid  out  1  result valid; held until consumed.
out_ready  in  1  consumer accepts result.
sum  out  DW  packed result register.
lane_ovfl  out  LANES  per-lane signed overflow flag, bit i = lane i.
error  out  1  OR of lane_ovfl.
busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, lane_ovfl=0, error=0, lane index=0, operand/sat latches=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and sat; clear sum and lane_ovfl; set idx=0; go to RUN.
- RUN: each cycle compute lane idx as s = A_i + B_i, truncated to LANE_W bits. ovf = (A_i[msb]==B_i[msb]) && (s[msb]!=A_i[msb]).
- If ovf&&sat: write 0111 when A_i[msb]==0, else 1000. Otherwise write s.
- Write the lane result to sum lane idx and ovf to lane_ovfl[idx]. idx increments.
- After lane LANES-1 is written, go to DONE with out_valid=1.
- Lane order is 0 first (bits 3:0), lane LANES-1 last.
- Latency: accept on edge N gives out_valid=1 after edge N+LANES (4 RUN cycles).
- DONE: out_valid=1. sum, lane_ovfl and error are stable and frozen. On out_ready go to IDLE and drop out_valid at that edge.
- Throughput: at most one operation per LANES+2 cycles. in_ready=0 in DONE, so a new request cannot be accepted on the same edge as the result handoff.
- sum and lane_ovfl are registered. During RUN they show partial results, and consumers sample them only when out_valid=1.
- error is combinational OR of lane_ovfl, valid when out_valid=1.
- abort=1 at an edge in any state: go to IDLE, out_valid=0, sum=0, lane_ovfl=0, idx=0.
- abort in IDLE with in_valid: abort wins and nothing is accepted.
- in_valid while busy is ignored; no queuing. a, b and sat changes after accept have no effect.
- out_ready while not in DONE is ignored.
- rst_n asserted mid-RUN or in DONE: immediate return to the reset values above; the partial result is discarded.
- Carry never propagates between lanes. The carry out of each lane is dropped.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-cycle, then release -> in_ready=1, out_valid=0, sum=0x0000, error=0, busy=0.
- Basic: a=0x1234, b=0x1111, sat=0, out_ready=1 -> out_valid exactly 4 cycles after the accept edge, sum=0x2345, lane_ovfl=0000, error=0, in_ready back to 1 one cycle later.
- Wrap vs saturate, positive overflow:
  - a=0x7777, b=0x1111, sat=0 -> sum=0x8888, lane_ovfl=1111, error=1.
  - Same operands with sat=1 -> sum=0x7777, lane_ovfl=1111.
- Mixed lanes, saturate: a=0x88F0, b=0x8F1F, sat=1 -> sum=0x880F, lane_ovfl=1100, error=1.
- Backpressure: complete any operation with out_ready=0 for 3 cycles -> out_valid, sum and lane_ovfl held constant, in_ready=0. Drop in_valid pulses presented in that window. Raise out_ready -> IDLE next edge.
- Abort/reset mid-op: accept a=0x7777, b=0x1111, assert abort in the 2nd RUN cycle -> IDLE next edge, out_valid never rises, sum=0x0000. Repeat with rst_n pulsed low instead -> same outcome. A subsequent 0x1234+0x1111 still yields 0x2345.
